// File: rtl/mxm_seq_if.sv
// Memory-read and result-stream bundle for mxm_seq; master is the sequencer,
// slave is the A/X memories plus the Y consumer.
interface mxm_seq_if #(
  parameter int W = 8,
  parameter int M = 4,
  parameter int N = 8,
  parameter int P = 4
);
  localparam int AAW = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int XAW = (N * P > 1) ? $clog2(N * P) : 1;
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int CW  = (P > 1) ? $clog2(P) : 1;

  logic           start;
  logic [AAW-1:0] a_addr;
  logic [XAW-1:0] x_addr;
  logic           rd_en;
  logic [W-1:0]   a_data;
  logic [W-1:0]   x_data;
  logic [W-1:0]   y_data;
  logic [RW-1:0]  y_row;
  logic [CW-1:0]  y_col;
  logic           y_valid;
  logic           y_ready;
  logic           busy;
  logic           done;

  modport master (
    input  start, a_data, x_data, y_ready,
    output a_addr, x_addr, rd_en, y_data, y_row, y_col, y_valid, busy, done
  );

  modport slave (
    output start, a_data, x_data, y_ready,
    input  a_addr, x_addr, rd_en, y_data, y_row, y_col, y_valid, busy, done
  );
endinterface

// File: rtl/mxm_seq.sv
// Sequential (MxN)x(NxP) matrix product: one MAC per cycle, first result N+2 cycles after start.
// A full output register stalls only the k=N-1 issue; earlier issues of a dot product always proceed.
module mxm_seq #(
  parameter int W = 8,
  parameter int M = 4,
  parameter int N = 8,
  parameter int P = 4
) (
  input  logic       clk,
  input  logic       rst,
  mxm_seq_if.master  bus
);
  localparam int AAW = (M * N > 1) ? $clog2(M * N) : 1;
  localparam int XAW = (N * P > 1) ? $clog2(N * P) : 1;
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int CW  = (P > 1) ? $clog2(P) : 1;
  localparam int KW  = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        r_state;
  logic [RW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [KW-1:0] r_k;
  logic          r_busy;
  logic          r_done;

  logic          r_p_vld;
  logic          r_p_first;
  logic          r_p_last;
  logic [RW-1:0] r_p_row;
  logic [CW-1:0] r_p_col;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_y_data;
  logic [RW-1:0] r_y_row;
  logic [CW-1:0] r_y_col;
  logic          r_y_valid;

  logic          w_k_last;
  logic          w_j_last;
  logic          w_i_last;
  logic          w_stall;
  logic          w_issue;
  logic          w_xfer;
  logic          w_final_xfer;
  logic [W-1:0]  w_prod;
  logic [W-1:0]  w_sum;

  assign w_k_last     = (r_k == KW'(N - 1));
  assign w_j_last     = (r_j == CW'(P - 1));
  assign w_i_last     = (r_i == RW'(M - 1));
  // The stall input is y_ready itself, so the read strobe has to be combinational.
  assign w_stall      = w_k_last && r_y_valid && !bus.y_ready;
  assign w_issue      = (r_state == S_RUN) && !w_stall;
  assign w_xfer       = r_y_valid && bus.y_ready;
  assign w_final_xfer = w_xfer && (r_y_row == RW'(M - 1)) && (r_y_col == CW'(P - 1));

  assign w_prod = bus.a_data * bus.x_data;
  assign w_sum  = (r_p_first ? '0 : r_acc) + w_prod;

  assign bus.rd_en   = w_issue;
  assign bus.a_addr  = w_issue ? AAW'(int'(r_i) * N + int'(r_k)) : '0;
  assign bus.x_addr  = w_issue ? XAW'(int'(r_k) * P + int'(r_j)) : '0;
  assign bus.y_data  = r_y_data;
  assign bus.y_row   = r_y_row;
  assign bus.y_col   = r_y_col;
  assign bus.y_valid = r_y_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
          end
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_k_last) begin
              r_k <= '0;
              if (w_j_last) begin
                r_j <= '0;
                r_i <= w_i_last ? '0 : r_i + 1'b1;
                if (w_i_last) r_state <= S_DRAIN;
              end else begin
                r_j <= r_j + 1'b1;
              end
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_final_xfer) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read data lands one cycle after the issue; tags travel alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_vld   <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      r_p_row   <= '0;
      r_p_col   <= '0;
      r_acc     <= '0;
      r_y_data  <= '0;
      r_y_row   <= '0;
      r_y_col   <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_p_vld   <= w_issue;
      r_p_first <= (r_k == '0);
      r_p_last  <= w_k_last;
      r_p_row   <= r_i;
      r_p_col   <= r_j;
      if (r_p_vld) r_acc <= w_sum;
      if (r_p_vld && r_p_last) begin
        r_y_data  <= w_sum;
        r_y_row   <= r_p_row;
        r_y_col   <= r_p_col;
        r_y_valid <= 1'b1;
      end else if (w_xfer) begin
        r_y_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mxm_seq.sv
// Randomized bench for mxm_seq against a nested-loop matrix product model.
module tb_mxm_seq;
  localparam int W    = 8;
  localparam int M    = 2;
  localparam int N    = 2;
  localparam int P    = 3;
  localparam int NRES = M * P;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mxm_seq_if #(.W(W), .M(M), .N(N), .P(P)) bus ();

  mxm_seq #(.W(W), .M(M), .N(N), .P(P)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] mem_a [M*N];
  logic [W-1:0] mem_x [N*P];

  // Memory model: data valid exactly one cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_data <= mem_a[bus.a_addr];
      bus.x_data <= mem_x[bus.x_addr];
    end else begin
      bus.a_data <= 'x;
      bus.x_data <= 'x;
    end
  end

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_val [$];
  int           exp_row [$];
  int           exp_col [$];
  logic [W-1:0] got_val [$];
  int           got_row [$];
  int           got_col [$];
  int           got_cyc [$];

  int first_rd, first_vld, done_cyc, done_cnt;
  int hold_err, stall_err, busy_err, tail_rd, tail_done, list_err;
  bit timed_out;

  task automatic fill_random();
    for (int i = 0; i < M * N; i++) mem_a[i] = W'($urandom_range(0, 255));
    for (int i = 0; i < N * P; i++) mem_x[i] = W'($urandom_range(0, 255));
  endtask

  task automatic build_model();
    exp_val.delete(); exp_row.delete(); exp_col.delete();
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < P; j++) begin
        int unsigned s;
        s = 0;
        for (int k = 0; k < N; k++) s += mem_a[i*N+k] * mem_x[k*P+j];
        exp_val.push_back(W'(s % (1 << W)));
        exp_row.push_back(i);
        exp_col.push_back(j);
      end
    end
  endtask

  // Runs one job from the IDLE state; mode 0: ready high, 1: random ready, 2: ready low 10 cycles at first result.
  task automatic run_job(input int mode, input bit spam);
    bit           prev_hold;
    bit           stalled;
    bit           seen_done;
    logic [W-1:0] pv;
    int           pr, pc, stall_left, cyc;
    build_model();
    got_val.delete(); got_row.delete(); got_col.delete(); got_cyc.delete();
    first_rd = -1; first_vld = -1; done_cyc = -1; done_cnt = 0;
    hold_err = 0; stall_err = 0; busy_err = 0; tail_rd = 0; tail_done = 0; list_err = 0;
    prev_hold = 0; stalled = 0; seen_done = 0; stall_left = 0;
    pv = '0; pr = 0; pc = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (!seen_done && cyc < 2000) begin
      if (mode == 2 && !stalled && bus.y_valid) begin
        stall_left = 10;
        stalled    = 1;
      end
      if (mode == 1)      bus.y_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2) bus.y_ready = (stall_left == 0);
      else                bus.y_ready = 1'b1;
      if (stall_left > 0) stall_left--;
      if (spam) bus.start = 1'($urandom_range(0, 1));
      #1;
      if (prev_hold && (!bus.y_valid || bus.y_data !== pv || int'(bus.y_row) != pr || int'(bus.y_col) != pc))
        hold_err++;
      if (bus.rd_en && bus.y_valid && !bus.y_ready && (int'(bus.a_addr) % N == N - 1)) stall_err++;
      if (bus.rd_en && first_rd < 0) first_rd = cyc;
      if (bus.y_valid && first_vld < 0) first_vld = cyc;
      if (bus.done) begin
        seen_done = 1;
        done_cyc  = cyc;
        done_cnt++;
        if (bus.busy) busy_err++;
      end else if (!bus.busy) begin
        busy_err++;
      end
      if (bus.y_valid && bus.y_ready) begin
        got_val.push_back(bus.y_data);
        got_row.push_back(int'(bus.y_row));
        got_col.push_back(int'(bus.y_col));
        got_cyc.push_back(cyc);
      end
      prev_hold = bus.y_valid && !bus.y_ready;
      pv = bus.y_data; pr = int'(bus.y_row); pc = int'(bus.y_col);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start   = 1'b0;
    bus.y_ready = 1'b1;
    timed_out   = !seen_done;
    repeat (3 * N + 4) begin
      #1;
      if (bus.rd_en || bus.y_valid) tail_rd++;
      if (bus.done) tail_done++;
      if (bus.busy) busy_err++;
      @(posedge clk); #1;
    end
    if (got_val.size() != exp_val.size()) list_err++;
    for (int n = 0; n < got_val.size() && n < exp_val.size(); n++)
      if (got_val[n] !== exp_val[n] || got_row[n] != exp_row[n] || got_col[n] != exp_col[n]) list_err++;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b1; bus.y_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.rd_en !== 1'b0)   begin bad++; $display("FAIL reset_rd_en got %b want 0", bus.rd_en); end
    total++; if (bus.y_valid !== 1'b0) begin bad++; $display("FAIL reset_y_valid got %b want 0", bus.y_valid); end
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0)    begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    total++; if (bus.a_addr !== '0 || bus.x_addr !== '0)
      begin bad++; $display("FAIL reset_addr got a=%0d x=%0d want 0", bus.a_addr, bus.x_addr); end
    total++; if (bus.y_data !== '0 || bus.y_row !== '0 || bus.y_col !== '0)
      begin bad++; $display("FAIL reset_y got %0d (%0d,%0d) want 0 (0,0)", bus.y_data, bus.y_row, bus.y_col); end
    rst = 1'b0; bus.start = 1'b0; bus.y_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.rd_en !== 1'b0 || bus.busy !== 1'b0)
      begin bad++; $display("FAIL reset_start_ignored got rd_en=%b busy=%b want 0 0", bus.rd_en, bus.busy); end
  endtask

  task automatic test_latency();
    logic [W-1:0] v0;
    fill_random();
    mem_a[0] = 8'd3; mem_a[1] = 8'd4; mem_x[0] = 8'd5; mem_x[P] = 8'd6;
    run_job(0, 0);
    v0 = (got_val.size() > 0) ? got_val[0] : 'x;
    total++; if (timed_out) begin bad++; $display("FAIL lat_timeout got timeout want done"); end
    total++; if (first_rd != 1) begin bad++; $display("FAIL lat_first_rd got %0d want 1", first_rd); end
    total++; if (first_vld != N + 2) begin bad++; $display("FAIL lat_first_vld got %0d want %0d", first_vld, N + 2); end
    total++; if (v0 !== 8'd39) begin bad++; $display("FAIL lat_y00 got %0d want 39", v0); end
    total++; if (got_cyc.size() != NRES || done_cyc != got_cyc[got_cyc.size()-1] + 1)
      begin bad++; $display("FAIL lat_done_cycle got %0d results=%0d want last_xfer+1", done_cyc, got_cyc.size()); end
    total++; if (list_err != 0) begin bad++; $display("FAIL lat_results got %0d mismatches want 0", list_err); end
    total++; if (busy_err != 0) begin bad++; $display("FAIL lat_busy got %0d busy errors want 0", busy_err); end
    total++; if (tail_rd != 0 || tail_done != 0)
      begin bad++; $display("FAIL lat_tail got rd/vld=%0d done=%0d want 0 0", tail_rd, tail_done); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] v0;
    fill_random();
    mem_a[0] = 8'd255; mem_a[1] = 8'd255; mem_x[0] = 8'd2; mem_x[P] = 8'd2;
    run_job(0, 0);
    v0 = (got_val.size() > 0) ? got_val[0] : 'x;
    total++; if (v0 !== 8'd252) begin bad++; $display("FAIL wrap_y00 got %0d want 252", v0); end
    total++; if (list_err != 0) begin bad++; $display("FAIL wrap_results got %0d mismatches want 0", list_err); end
  endtask

  task automatic test_spacing();
    int verr, serr;
    for (int i = 0; i < M * N; i++) mem_a[i] = 8'd1;
    for (int i = 0; i < N * P; i++) mem_x[i] = 8'd1;
    run_job(0, 0);
    verr = 0; serr = 0;
    foreach (got_val[n]) if (got_val[n] !== W'(N)) verr++;
    for (int n = 1; n < got_cyc.size(); n++) if (got_cyc[n] - got_cyc[n-1] != N) serr++;
    total++; if (got_val.size() != NRES || verr != 0)
      begin bad++; $display("FAIL ones_values got %0d results %0d wrong want %0d results of %0d", got_val.size(), verr, NRES, N); end
    total++; if (serr != 0) begin bad++; $display("FAIL ones_spacing got %0d gaps wrong want 0", serr); end
    total++; if (list_err != 0) begin bad++; $display("FAIL ones_order got %0d mismatches want 0", list_err); end
  endtask

  task automatic test_backpressure();
    fill_random();
    run_job(2, 0);
    total++; if (hold_err != 0) begin bad++; $display("FAIL bp_hold got %0d changes want 0", hold_err); end
    total++; if (stall_err != 0) begin bad++; $display("FAIL bp_withheld got %0d last-k issues want 0", stall_err); end
    total++; if (got_cyc.size() == 0 || got_cyc[0] != first_vld + 10)
      begin bad++; $display("FAIL bp_first_xfer got results=%0d want xfer at cycle %0d", got_cyc.size(), first_vld + 10); end
    total++; if (got_val.size() != NRES || list_err != 0)
      begin bad++; $display("FAIL bp_results got %0d results %0d mismatches want %0d 0", got_val.size(), list_err, NRES); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_random_ready();
    for (int it = 0; it < 6; it++) begin
      fill_random();
      run_job(1, 0);
      total++; if (timed_out || list_err != 0)
        begin bad++; $display("FAIL rnd_results iter %0d got timeout=%0b mismatches=%0d want 0 0", it, timed_out, list_err); end
      total++; if (hold_err != 0 || stall_err != 0)
        begin bad++; $display("FAIL rnd_flow iter %0d got hold=%0d stall=%0d want 0 0", it, hold_err, stall_err); end
    end
  endtask

  task automatic test_start_while_busy();
    for (int it = 0; it < 3; it++) begin
      fill_random();
      run_job(1, 1);
      total++; if (done_cnt != 1 || tail_done != 0)
        begin bad++; $display("FAIL spam_done iter %0d got %0d+%0d want 1", it, done_cnt, tail_done); end
      total++; if (list_err != 0 || tail_rd != 0)
        begin bad++; $display("FAIL spam_results iter %0d got mismatches=%0d tail=%0d want 0 0", it, list_err, tail_rd); end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    fill_random();
    bus.y_ready = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      if (bus.y_valid) found = 1;
      else begin @(posedge clk); #1; end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_wait got no y_valid want y_valid"); end
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.y_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rd_en !== 1'b0)
      begin bad++; $display("FAIL mid_rst got vld=%b busy=%b rd=%b want 0 0 0", bus.y_valid, bus.busy, bus.rd_en); end
    total++; if (bus.y_data !== '0) begin bad++; $display("FAIL mid_rst_y got %0d want 0", bus.y_data); end
    rst = 1'b0;
    @(posedge clk); #1;
    fill_random();
    run_job(0, 0);
    total++; if (timed_out || list_err != 0 || got_val.size() != NRES)
      begin bad++; $display("FAIL mid_rerun got %0d results %0d mismatches want %0d 0", got_val.size(), list_err, NRES); end
    total++; if (first_rd != 1) begin bad++; $display("FAIL mid_rerun_rd got %0d want 1", first_rd); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.y_ready = 1'b1;
    test_reset();
    test_latency();
    test_wrap();
    test_spacing();
    test_backpressure();
    test_random_ready();
    test_start_while_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mxm_seq.md
MXM_SEQ -- requirements
Module: mxm_seq

Interface
REQ-001 Parameters, one per line (name, default, meaning): W 8 operand/result bit-width; M 4 rows of A; N 8 inner dimension, N>=2; P 4 columns of X.
REQ-002 clk  in  1  clock; all state SHALL update on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  begin one (MxN)x(NxP) product; sampled only in IDLE.
REQ-005 a_addr  out  clog2(M*N)  A read address, row-major, i*N+k.
REQ-006 x_addr  out  clog2(N*P)  X read address, row-major, k*P+j.
REQ-007 rd_en  out  1  read strobe for both memories; data SHALL be returned exactly 1 cycle later.
REQ-008 a_data, x_data  in  W each  memory read data.
REQ-009 y_data  out  W  result element Y[i][j].
REQ-010 y_row, y_col  out  clog2(M), clog2(P)  indices of y_data.
REQ-011 y_valid  out  1; y_ready  in  1; a transfer occurs when both are high in the same cycle.
REQ-012 busy  out  1  high from start acceptance until done.
REQ-013 done  out  1  one-cycle pulse ending the job.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after the (M-1,P-1,N-1) issue; DRAIN->DONE on the final y transfer; DONE->IDLE unconditionally.
REQ-015 Issue order SHALL be i outer, j middle, k inner; one (i,j,k) issue per RUN cycle unless stalled.
REQ-016 Stall: an issue with k=N-1 SHALL be held (rd_en low, counters frozen) while y_valid=1 and y_ready=0; issues with k<N-1 are never stalled.
REQ-017 One cycle after each issue, the accumulator SHALL load a_data*x_data if k was 0, else acc + a_data*x_data; all arithmetic unsigned, truncated modulo 2^W.
REQ-018 One cycle after the k=N-1 data arrives, y_data/y_row/y_col SHALL hold the result and y_valid SHALL be 1; the output register is guaranteed free by REQ-016.
REQ-019 y_data/y_row/y_col SHALL remain stable while y_valid=1 and y_ready=0; y_valid SHALL clear after a transfer unless a new result loads the same cycle.
REQ-020 Latency: start sampled in cycle 0 -> first rd_en cycle 1 -> first y_valid cycle N+2 (y_ready held high); steady throughput one result per N cycles.
REQ-021 Results SHALL appear in row-major order (0,0),(0,1)...(M-1,P-1), exactly M*P transfers per job.
REQ-022 busy SHALL rise the cycle after start is accepted and fall with the done pulse; start while busy or in DONE SHALL be ignored.
REQ-023 done SHALL pulse in the cycle after the final y transfer; a start in that cycle is ignored.
REQ-024 a_addr/x_addr SHALL be 0 whenever rd_en is 0 outside RUN.

Reset
REQ-025 rst SHALL force IDLE and clear rd_en, y_valid, busy, done, addresses, counters, accumulator and y_data/y_row/y_col to 0, with priority over all other inputs.
REQ-026 rst mid-job SHALL abandon the job without further rd_en or y_valid; the next start begins a fresh job from (0,0,0).

Verification
REQ-027 M=1,N=2,P=1, A=[3,4], X=[5,6], y_ready=1 -> y_valid in cycle 4 with y_data=39, (0,0); done pulses cycle 5.
REQ-028 M=2,N=3,P=2, all elements 1, y_ready=1 -> four results of 3 in order (0,0),(0,1),(1,0),(1,1), spaced 3 cycles apart.
REQ-029 W=8,N=2, A=[255,255], X=[2,2] -> y_data=252 (1020 mod 256).
REQ-030 y_ready low for 10 cycles at first result -> y_data held constant, next k=N-1 issue withheld, no result lost or duplicated, total M*P transfers.
REQ-031 rst asserted mid-RUN with y_valid=1 -> next cycle y_valid=0, busy=0, rd_en=0; new start yields the full correct result set.
REQ-032 start pulsed while busy -> ignored; exactly one done per accepted start.
